// File: rtl/axi_mem_responder_if.sv
// AXI4 bus bundle shared by the stage chain. The "master" modport is the terminating
// responder's view (it drives the ready and response signals); "slave" is the initiator's view.
interface axi_bus_t;
  logic [15:0]  awid;
  logic [63:0]  awaddr;
  logic [7:0]   awlen;
  logic [2:0]   awsize;
  logic         awvalid;
  logic         awready;

  logic [511:0] wdata;
  logic [63:0]  wstrb;
  logic         wlast;
  logic         wvalid;
  logic         wready;

  logic [15:0]  bid;
  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready;

  logic [15:0]  arid;
  logic [63:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic         arvalid;
  logic         arready;

  logic [15:0]  rid;
  logic [511:0] rdata;
  logic [1:0]   rresp;
  logic         rlast;
  logic         rvalid;
  logic         rready;

  modport master (
    input  awid, awaddr, awlen, awsize, awvalid,
    input  wdata, wstrb, wlast, wvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arvalid,
    input  rready,
    output awready, wready, bid, bresp, bvalid,
    output arready, rid, rdata, rresp, rlast, rvalid
  );

  modport slave (
    output awid, awaddr, awlen, awsize, awvalid,
    output wdata, wstrb, wlast, wvalid,
    output bready,
    output arid, araddr, arlen, arsize, arvalid,
    output rready,
    input  awready, wready, bid, bresp, bvalid,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi_mem_responder.sv
// Terminating AXI4 responder backed by a 512-bit-wide on-chip memory. Independent write
// (AW/W/B) and read (AR/R) FSMs, one burst in flight per direction.
module axi_mem_responder #(
  parameter bit EN_WR  = 1'b1,
  parameter bit EN_RD  = 1'b1,
  parameter int MEM_LD = 10
) (
  input logic      clk,
  input logic      rst,
  axi_bus_t.master axi_s
);
  localparam int DEPTH = 1 << MEM_LD;

  typedef logic [MEM_LD-1:0] line_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;

  logic [511:0] mem [DEPTH];

  w_state_e     w_state, w_state_nxt;
  logic [15:0]  w_id;
  line_t        w_line;
  logic [7:0]   w_len, w_cnt;
  logic         w_size_ok, w_err;
  logic         aw_fire, w_fire, w_final;

  r_state_e     r_state, r_state_nxt;
  logic [15:0]  r_id;
  line_t        r_line, r_line_nxt, ar_line;
  logic [7:0]   r_len, r_cnt;
  logic         r_size_ok, r_last;
  logic [511:0] r_data;
  logic         ar_fire, r_adv;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{axi_s.awaddr[5:0], axi_s.awaddr[63:6+MEM_LD],
                              axi_s.araddr[5:0], axi_s.araddr[63:6+MEM_LD]};

  assign aw_fire    = axi_s.awvalid & axi_s.awready;
  assign w_fire     = axi_s.wvalid & axi_s.wready;
  assign w_final    = axi_s.wlast | (w_cnt == w_len);
  assign ar_fire    = axi_s.arvalid & axi_s.arready;
  assign r_adv      = axi_s.rvalid & axi_s.rready & ~r_last;
  assign ar_line    = axi_s.araddr[6 +: MEM_LD];
  assign r_line_nxt = r_line + 1'b1;

  // ---------------- write path ----------------
  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) w_state <= W_IDLE;
    else     w_state <= w_state_nxt;
  end

  // NOTE: every output and next-state gets a default first, so no path infers a latch.
  always_comb begin
    w_state_nxt   = w_state;
    axi_s.awready = 1'b0;
    axi_s.wready  = 1'b0;
    axi_s.bvalid  = 1'b0;
    axi_s.bid     = '0;
    axi_s.bresp   = 2'b00;
    if (EN_WR && !rst) begin
      case (w_state)
        W_IDLE: begin
          axi_s.awready = 1'b1;
          if (axi_s.awvalid) w_state_nxt = W_DATA;
        end
        W_DATA: begin
          axi_s.wready = 1'b1;
          if (axi_s.wvalid && w_final) w_state_nxt = W_RESP;
        end
        W_RESP: begin
          axi_s.bvalid = 1'b1;
          axi_s.bid    = w_id;
          axi_s.bresp  = w_err ? 2'b10 : 2'b00;
          if (axi_s.bready) w_state_nxt = W_IDLE;
        end
        default: w_state_nxt = W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_id      <= '0;
      w_line    <= '0;
      w_len     <= '0;
      w_cnt     <= '0;
      w_size_ok <= 1'b0;
      w_err     <= 1'b0;
    end else begin
      if (aw_fire) begin
        w_id      <= axi_s.awid;
        w_line    <= axi_s.awaddr[6 +: MEM_LD];
        w_len     <= axi_s.awlen;
        w_cnt     <= '0;
        w_size_ok <= (axi_s.awsize == 3'd6);
        w_err     <= 1'b0;
      end
      if (w_fire) begin
        // Early wlast and a missing wlast both end the burst, flagged as SLVERR.
        if (w_final) w_err <= ~w_size_ok | (axi_s.wlast != (w_cnt == w_len));
        else begin
          w_cnt  <= w_cnt + 8'd1;
          w_line <= w_line + 1'b1;
        end
      end
    end
  end

  // NOTE: memory is deliberately not reset; only control state is.
  always_ff @(posedge clk) begin
    if (w_fire && w_size_ok) begin
      for (int i = 0; i < 64; i++) begin
        if (axi_s.wstrb[i]) mem[w_line][8*i +: 8] <= axi_s.wdata[8*i +: 8];
      end
    end
  end

  // ---------------- read path ----------------
  always_ff @(posedge clk) begin
    if (rst) r_state <= R_IDLE;
    else     r_state <= r_state_nxt;
  end

  always_comb begin
    r_state_nxt   = r_state;
    axi_s.arready = 1'b0;
    axi_s.rvalid  = 1'b0;
    axi_s.rid     = '0;
    axi_s.rdata   = '0;
    axi_s.rresp   = 2'b00;
    axi_s.rlast   = 1'b0;
    if (EN_RD && !rst) begin
      case (r_state)
        R_IDLE: begin
          axi_s.arready = 1'b1;
          if (axi_s.arvalid) r_state_nxt = R_DATA;
        end
        R_DATA: begin
          axi_s.rvalid = 1'b1;
          axi_s.rid    = r_id;
          axi_s.rdata  = r_data;
          axi_s.rresp  = r_size_ok ? 2'b00 : 2'b10;
          axi_s.rlast  = r_last;
          if (axi_s.rready && r_last) r_state_nxt = R_IDLE;
        end
        default: r_state_nxt = R_IDLE;
      endcase
    end
  end

  // Beat registers reload in the accepting edge, so R streams with no bubble; reading mem
  // alongside a same-edge write returns the old line contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_id      <= '0;
      r_line    <= '0;
      r_len     <= '0;
      r_cnt     <= '0;
      r_size_ok <= 1'b0;
      r_last    <= 1'b0;
      r_data    <= '0;
    end else if (ar_fire) begin
      r_id      <= axi_s.arid;
      r_line    <= ar_line;
      r_len     <= axi_s.arlen;
      r_cnt     <= '0;
      r_size_ok <= (axi_s.arsize == 3'd6);
      r_last    <= (axi_s.arlen == 8'd0);
      r_data    <= (axi_s.arsize == 3'd6) ? mem[ar_line] : '0;
    end else if (r_adv) begin
      r_cnt  <= r_cnt + 8'd1;
      r_line <= r_line_nxt;
      r_last <= ((r_cnt + 8'd1) == r_len);
      r_data <= r_size_ok ? mem[r_line_nxt] : '0;
    end
  end
endmodule
